// File: rtl/led_pattern_monitor.sv
// Far-end observer of the rotating LED bus: verifies each change is a one-position
// left rotation at the expected cadence, counts good steps and latches error flags.
module led_pattern_monitor #(
  parameter  int CLK_FREQ = 25_000_000,
  parameter  int TOL      = 2,
  localparam int PW       = $clog2(2*CLK_FREQ+1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    leds_in,
  input  logic          clear,
  output logic          locked,
  output logic          step_pulse,
  output logic [15:0]   step_count,
  output logic [PW-1:0] period,
  output logic          rot_err,
  output logic          per_err,
  output logic          stall
);

  localparam logic [PW-1:0] CMAX = PW'(2*CLK_FREQ);
  localparam logic [PW:0]   PLO  = (CLK_FREQ > TOL) ? (PW+1)'(CLK_FREQ-TOL) : '0;
  localparam logic [PW:0]   PHI  = (PW+1)'(CLK_FREQ+TOL);

  typedef enum logic [1:0] {ACQ, MEAS, LOCK} state_t;

  state_t        state, state_nx;
  logic [7:0]    s1, s2, prev;
  logic [PW-1:0] cnt;
  logic [PW:0]   per_new;
  logic          change, rot_ok, per_ok;
  logic          do_step, set_rot, set_per, set_stall;

  assign change  = (s2 != prev);
  assign per_new = {1'b0, cnt} + 1'b1;
  assign rot_ok  = (s2 == {prev[6:0], prev[7]});
  assign per_ok  = (per_new >= PLO) && (per_new <= PHI);
  assign locked  = (state == LOCK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACQ;
    else        state <= state_nx;
  end

  // A change on the same edge the counter would saturate wins over the stall.
  always_comb begin
    state_nx  = state;
    do_step   = 1'b0;
    set_rot   = 1'b0;
    set_per   = 1'b0;
    set_stall = 1'b0;
    if (clear) begin
      state_nx = ACQ;
    end else if (change) begin
      case (state)
        ACQ: state_nx = MEAS;
        MEAS, LOCK: begin
          set_rot = !rot_ok;
          set_per = !per_ok;
          if (rot_ok && per_ok) begin
            do_step  = 1'b1;
            state_nx = LOCK;
          end else begin
            state_nx = MEAS;
          end
        end
        default: state_nx = ACQ;
      endcase
    end else if (state != ACQ && cnt == CMAX - 1'b1) begin
      set_stall = 1'b1;
      state_nx  = ACQ;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1         <= '0;
      s2         <= '0;
      prev       <= '0;
      cnt        <= '0;
      period     <= '0;
      step_pulse <= 1'b0;
      step_count <= '0;
      rot_err    <= 1'b0;
      per_err    <= 1'b0;
      stall      <= 1'b0;
    end else begin
      s1         <= leds_in;
      s2         <= s1;
      step_pulse <= do_step;
      if (clear) begin
        // Re-base on whatever is on the bus now; period keeps its last value.
        prev       <= s2;
        cnt        <= '0;
        step_count <= '0;
        rot_err    <= 1'b0;
        per_err    <= 1'b0;
        stall      <= 1'b0;
      end else begin
        if (change) begin
          prev   <= s2;
          period <= per_new[PW-1:0];
          cnt    <= '0;
        end else if (cnt != CMAX) begin
          cnt <= cnt + 1'b1;
        end
        if (do_step)   step_count <= step_count + 16'd1;
        if (set_rot)   rot_err    <= 1'b1;
        if (set_per)   per_err    <= 1'b1;
        if (set_stall) stall      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_monitor.sv
// Bench for led_pattern_monitor: directed vector table, stall/clear/reset sequences,
// then random LED events checked against an event-level reference model.
module tb_led_pattern_monitor;
  localparam int CF = 10;
  localparam int TL = 1;
  localparam int PW = $clog2(2*CF+1);

  logic          clk = 1'b0, rst_n = 1'b0, clear = 1'b0;
  logic [7:0]    leds_in = 8'h00;
  logic          locked, step_pulse, rot_err, per_err, stall;
  logic [15:0]   step_count;
  logic [PW-1:0] period;

  led_pattern_monitor #(.CLK_FREQ(CF), .TOL(TL)) dut (
    .clk(clk), .rst_n(rst_n), .leds_in(leds_in), .clear(clear),
    .locked(locked), .step_pulse(step_pulse), .step_count(step_count),
    .period(period), .rot_err(rot_err), .per_err(per_err), .stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pat;    // new LED value
    int         gap;    // cycles until the next event
    bit         clr;    // pulse clear on the detection edge
    bit         rel;    // release reset instead of a plain change
    bit         pulse;
    int         count;
    bit         lck, rot, per, stl;
    int         period;
  } vec_t;

  int n_pass = 0, n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else n_pass++;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_pulse"},  int'(step_pulse), 0);
    chk({tag, "_count"},  int'(step_count), 0);
    chk({tag, "_period"}, int'(period), 0);
    chk({tag, "_rot"},    int'(rot_err), 0);
    chk({tag, "_per"},    int'(per_err), 0);
    chk({tag, "_stall"},  int'(stall), 0);
  endtask

  // Drive one event at a negedge; detection is visible at the third negedge.
  task automatic apply(input vec_t e, input string tag);
    int pulses = 0;
    bit at3 = 1'b0;
    leds_in = e.pat;
    if (e.rel) rst_n = 1'b1;
    for (int k = 1; k <= e.gap; k++) begin
      @(negedge clk);
      if (e.clr && k == 2) clear = 1'b1;
      if (e.clr && k == 3) clear = 1'b0;
      if (step_pulse) pulses++;
      if (k == 3) begin
        at3 = step_pulse;
        chk({tag, "_count"},  int'(step_count), e.count);
        chk({tag, "_locked"}, int'(locked), int'(e.lck));
        chk({tag, "_rot"},    int'(rot_err), int'(e.rot));
        chk({tag, "_per"},    int'(per_err), int'(e.per));
        chk({tag, "_stall"},  int'(stall), int'(e.stl));
        chk({tag, "_period"}, int'(period), e.period);
      end
    end
    chk({tag, "_pulse_at_detect"}, int'(at3), int'(e.pulse));
    chk({tag, "_pulse_total"}, pulses, int'(e.pulse));
  endtask

  // Event-level reference: works on intervals between changes, not on cycles.
  int         m_mode;  // 0 acquiring, 1 measuring, 2 locked
  logic [7:0] m_base;
  int         m_count, m_period;
  bit         m_rot, m_per, m_stall, m_pulse;

  task automatic model_event(input logic [7:0] pat, input int interval, input bit clr,
                             input bit rel);
    bit rok, pok;
    if (rel) begin
      m_mode = 0; m_count = 0; m_period = 0; m_rot = 0; m_per = 0; m_stall = 0;
    end
    m_pulse = 0;
    if (m_mode != 0 && interval > 2*CF) begin
      m_stall = 1; m_mode = 0;
    end
    if (clr) begin
      m_count = 0; m_rot = 0; m_per = 0; m_stall = 0; m_mode = 0;
    end else begin
      m_period = (interval > 2*CF) ? 2*CF + 1 : interval;
      if (m_mode == 0) m_mode = 1;
      else begin
        rok = (pat == {m_base[6:0], m_base[7]});
        pok = (m_period >= CF - TL) && (m_period <= CF + TL);
        if (!rok) m_rot = 1;
        if (!pok) m_per = 1;
        if (rok && pok) begin
          m_pulse = 1; m_count = (m_count + 1) % 65536; m_mode = 2;
        end else m_mode = 1;
      end
    end
    m_base = pat;
  endtask

  vec_t v[14];

  initial begin
    vec_t e;
    logic [7:0] cur, nxt;
    int prev_gap;

    v[0]  = '{8'h1F, 10, 0, 1, 0, 0, 0, 0, 0, 0, 3};
    v[1]  = '{8'h3E, 10, 0, 0, 1, 1, 1, 0, 0, 0, 10};
    v[2]  = '{8'h7C, 10, 0, 0, 1, 2, 1, 0, 0, 0, 10};
    v[3]  = '{8'hF8, 10, 0, 0, 1, 3, 1, 0, 0, 0, 10};
    v[4]  = '{8'hF1, 10, 0, 0, 1, 4, 1, 0, 0, 0, 10};
    v[5]  = '{8'h3F, 10, 0, 0, 0, 4, 0, 1, 0, 0, 10};
    v[6]  = '{8'h7E, 11, 0, 0, 1, 5, 1, 1, 0, 0, 10};
    v[7]  = '{8'hFC, 12, 0, 0, 1, 6, 1, 1, 0, 0, 11};
    v[8]  = '{8'hF9, 10, 0, 0, 0, 6, 0, 1, 1, 0, 12};
    v[9]  = '{8'hF3, 10, 0, 0, 1, 7, 1, 1, 1, 0, 10};
    v[10] = '{8'hE7,  3, 0, 0, 1, 8, 1, 1, 1, 0, 10};
    v[11] = '{8'hCF, 10, 1, 0, 0, 0, 0, 0, 0, 0, 10};
    v[12] = '{8'h9F, 10, 0, 0, 0, 0, 0, 0, 0, 0, 10};
    v[13] = '{8'h3F,  3, 0, 0, 1, 1, 1, 0, 0, 0, 10};

    leds_in = 8'h1F;
    repeat (3) @(negedge clk);
    check_zero("reset");

    for (int i = 0; i < 14; i++) begin
      apply(v[i], $sformatf("vec%0d", i));
      if (i == 10) begin
        // Held bus after lock: stall exactly 2*CF edges after the last detection.
        repeat (2*CF - 1) @(negedge clk);
        chk("stall_before", int'(stall), 0);
        chk("stall_before_locked", int'(locked), 1);
        @(negedge clk);
        chk("stall_set", int'(stall), 1);
        chk("stall_locked", int'(locked), 0);
      end
    end

    // Asynchronous reset while locked with cnt = 5, then re-acquire cleanly.
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("midreset");
    @(negedge clk);
    for (int i = 0; i < 4; i++) apply(v[i], $sformatf("reacq%0d", i));

    // Random events against the reference model.
    rst_n = 1'b0;
    @(negedge clk);
    cur = 8'($urandom_range(1, 254));
    model_event(cur, 3, 1'b0, 1'b1);
    e = '{cur, 10, 0, 1, m_pulse, m_count, m_mode == 2, m_rot, m_per, m_stall, m_period};
    apply(e, "rnd_start");
    prev_gap = 10;
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 3) != 0) nxt = {cur[6:0], cur[7]};
      else nxt = 8'($urandom);
      while (nxt == cur) nxt = 8'($urandom);
      e.pat = nxt;
      e.rel = 1'b0;
      e.clr = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 9))
        0:       e.gap = $urandom_range(21, 26);
        1:       e.gap = $urandom_range(3, 7);
        default: e.gap = $urandom_range(8, 12);
      endcase
      model_event(nxt, prev_gap, e.clr, 1'b0);
      e.pulse = m_pulse; e.count = m_count; e.lck = (m_mode == 2);
      e.rot = m_rot; e.per = m_per; e.stl = m_stall; e.period = m_period;
      apply(e, $sformatf("rnd%0d", n));
      prev_gap = e.gap;
      cur = nxt;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
